uart_rx: RTL

- 8N1 UART receiver: no parity, LSB first, 1 stop bit. It is the receive-side counterpart of the team's uart_tx.
- Oversamples `serial_in` on the system clock and samples each bit at its centre.
- Presents each received byte with a one-cycle valid strobe and flags framing errors.
- Sits between the board RX pin and user logic. Target clock is 50 MHz.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 36 +++
 rtl/uart_rx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing derivation used by uart_rx and uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  function automatic int sample_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic int half_time(input int clock_freq, input int baud_rate);
    return sample_time(clock_freq, baud_rate) / 2;
  endfunction

  function automatic int cnt_width(input int clock_freq, input int baud_rate);
    return $clog2(sample_time(clock_freq, baud_rate));
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// RX pin synchronizer plus falling-edge detect; pin-to-rx_s latency 2 cycles, no backpressure.
// Flops reset high so an idle line never looks like a start edge out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  output logic rx_s,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic dly_q, dly_d;

  always_comb begin
    meta_d = serial_in;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      dly_q  <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign rx_s = sync_q;
  assign fall = dly_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver sampling at bit centres; byte valid 1 cycle after the stop-bit sample.
// No backpressure: uart_out is held until the next good byte, consumers take it on the valid strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] uart_out,
  output logic       uart_out_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int SAMPLE_TIME = sample_time(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_TIME   = half_time(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_WIDTH   = cnt_width(CLOCK_FREQ, BAUD_RATE);
  localparam logic [CNT_WIDTH-1:0] SAMPLE_LAST = CNT_WIDTH'(SAMPLE_TIME - 1);
  localparam logic [CNT_WIDTH-1:0] HALF_LAST   = CNT_WIDTH'(HALF_TIME - 1);

  logic rx_s, fall;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .rx_s      (rx_s),
    .fall      (fall)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_WIDTH'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        // Mid-start-bit recheck rejects short low glitches on an idle line.
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        // Leaving at the stop-bit centre leaves half a bit to catch a back-to-back start.
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            out_d   = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      out_q     <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign uart_out       = out_q;
  assign uart_out_valid = valid_q;
  assign frame_err      = ferr_q;
  assign rx_busy        = busy_q;

endmodule
